// File: rtl/fifo_pkt_reader.sv
// Read-side deframer for the synchronous byte FIFO.
// Turns length-prefixed bytes into a valid/ready payload stream.
module fifo_pkt_reader #(
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [7:0]       pkt_len,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] zero_len_count
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = $clog2(BUF_DEPTH + 1);

    typedef enum logic {S_HDR, S_PAY} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_buf [BUF_DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [OW-1:0]    r_occ;
    logic             r_inflight;
    logic [7:0]       r_rem;
    logic [7:0]       r_pkt_len;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_zl_cnt;

    logic             w_have;
    logic [7:0]       w_head;
    logic [OW:0]      w_level;
    logic             w_pop;
    logic             w_hdr;
    logic             w_zero;
    logic             w_done;
    logic             w_valid;
    logic             w_last;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_have  = (r_occ != '0);
    assign w_head  = r_buf[r_rd_ptr];
    assign w_level = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight};

    // Reserve a slot for every in-flight byte so the buffer can never overflow.
    assign fifo_rd_en = !rst && enable && !fifo_empty
                        && (w_level < (OW+1)'(BUF_DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_hdr       = 1'b0;
        w_zero      = 1'b0;
        w_done      = 1'b0;
        w_valid     = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            S_HDR: begin
                if (w_have) begin
                    w_pop = 1'b1;
                    w_hdr = 1'b1;
                    if (w_head == 8'd0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_state_nxt = S_PAY;
                    end
                end
            end
            S_PAY: begin
                w_valid = w_have;
                w_last  = w_have && (r_rem == 8'd1);
                if (w_have && out_ready) begin
                    w_pop = 1'b1;
                    if (r_rem == 8'd1) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_HDR;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HDR;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_rem      <= '0;
            r_pkt_len  <= '0;
            r_pkt_cnt  <= '0;
            r_zl_cnt   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= fifo_rd_en;
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= fifo_data;
                r_wr_ptr        <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            r_occ <= r_occ + OW'(r_inflight) - OW'(w_pop);
            if (w_hdr) begin
                r_pkt_len <= w_head;
                r_rem     <= w_head;
            end else if (w_pop) begin
                r_rem <= r_rem - 8'd1;
            end
            if (w_zero) begin
                r_zl_cnt <= r_zl_cnt + 1'b1;
            end
            if (w_done) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign out_valid      = w_valid;
    assign out_last       = w_last;
    assign out_data       = w_valid ? w_head : 8'd0;
    assign pkt_len        = r_pkt_len;
    assign busy           = (r_state == S_PAY) || w_have || r_inflight;
    assign pkt_count      = r_pkt_cnt;
    assign zero_len_count = r_zl_cnt;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: FIFO model, stream-level deframing model,
// per-cycle output compare, directed scenarios and a randomized run.
module tb_fifo_pkt_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'd0;
    logic        out_ready = 1'b0;
    logic        fifo_rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic [7:0]  pkt_len;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] zero_len_count;

    always #5 clk = ~clk;

    fifo_pkt_reader #(.BUF_DEPTH(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .pkt_len(pkt_len), .busy(busy),
        .pkt_count(pkt_count), .zero_len_count(zero_len_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Staging area written only by the stimulus; the FIFO model drains it.
    logic [7:0] stage_mem [16384];
    int         stage_wr = 0;
    int         stage_rd = 0;
    logic [7:0] fq [$];

    // Synchronous FIFO with one-cycle registered read, reset with the DUT.
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            stage_rd   = stage_wr;
            fifo_data  <= 8'd0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && fq.size() > 0) begin
                fifo_data <= fq.pop_front();
            end
            while (stage_rd != stage_wr) begin
                fq.push_back(stage_mem[stage_rd % 16384]);
                stage_rd++;
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Stream-level model: every byte sent is parsed as header/payload.
    logic [8:0] exp_q [$];
    int         m_rem = 0;
    int         m_pkts = 0;
    int         m_zl = 0;
    logic [7:0] m_len = 8'd0;

    task automatic send(input logic [7:0] b);
        stage_mem[stage_wr % 16384] = b;
        stage_wr++;
        if (m_rem == 0) begin
            m_len = b;
            if (b == 8'd0) m_zl++;
            else m_rem = int'(b);
        end else begin
            exp_q.push_back({(m_rem == 1), b});
            m_rem--;
            if (m_rem == 0) m_pkts++;
        end
    endtask

    // Per-cycle compare against the model.
    logic       stall_prev = 1'b0;
    logic [7:0] prev_d = 8'd0;
    logic       prev_l = 1'b0;

    always @(negedge clk) begin
        logic [8:0] e;
        #2;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_d));
                check("hold_last", 32'(out_last), 32'(prev_l));
            end
            if (fifo_rd_en) check("rd_when_empty", 32'(fifo_empty), 32'd0);
            if (!out_valid) check("last_unqual", 32'(out_last), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %02h expected none",
                             out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[7:0]));
                    check("out_last", 32'(out_last), 32'(e[8]));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    task automatic do_reset(input logic en, input logic rdy);
        @(negedge clk);
        rst       = 1'b1;
        enable    = en;
        out_ready = rdy;
        repeat (2) @(negedge clk);
        exp_q.delete();
        m_rem  = 0;
        m_pkts = 0;
        m_zl   = 0;
        m_len  = 8'd0;
        #1;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_len", 32'(pkt_len), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkts", 32'(pkt_count), 32'd0);
        check("rst_zl", 32'(zero_len_count), 32'd0);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !busy && fifo_empty
                && stage_rd == stage_wr) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got busy=%0d expected idle", busy);
        end
        check("pkt_count", 32'(pkt_count), 32'(m_pkts));
        check("zero_len_count", 32'(zero_len_count), 32'(m_zl));
        check("pkt_len", 32'(pkt_len), 32'(m_len));
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    logic [7:0] t1_data [3] = '{8'hA1, 8'hB2, 8'hC3};

    initial begin
        logic [7:0] rnd_bytes [$];
        int         idx;
        int         plen;
        bit         seen;

        // Test 1: single packet with cycle-exact timing.
        do_reset(1'b1, 1'b1);
        send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            #1;
            check("t1_rd_en", 32'(fifo_rd_en), 32'(k <= 3));
            check("t1_valid", 32'(out_valid), 32'(k >= 3 && k <= 5));
            if (k >= 3 && k <= 5)
                check("t1_data", 32'(out_data), 32'(t1_data[k-3]));
            check("t1_last", 32'(out_last), 32'(k == 5));
            if (k == 6) begin
                check("t1_len", 32'(pkt_len), 32'h03);
                check("t1_pkts", 32'(pkt_count), 32'd1);
            end
        end
        drain(50);

        // Test 2: back-to-back packets.
        do_reset(1'b1, 1'b1);
        send(8'h02); send(8'h11); send(8'h22); send(8'h01); send(8'h33);
        drain(50);
        check("t2_pkts", 32'(pkt_count), 32'd2);

        // Test 3: zero-length header followed by a packet.
        do_reset(1'b1, 1'b1);
        send(8'h00); send(8'h01); send(8'h44);
        drain(50);
        check("t3_zl", 32'(zero_len_count), 32'd1);
        check("t3_pkts", 32'(pkt_count), 32'd1);

        // Test 4: backpressure fills the holding buffer.
        do_reset(1'b1, 1'b0);
        send(8'h05);
        for (int i = 1; i <= 5; i++) send(8'(i));
        repeat (10) @(negedge clk);
        #1;
        check("t4_rd_full", 32'(fifo_rd_en), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_head", 32'(out_data), 32'h01);
        drain(50);

        // Test 5: enable dropped after the first payload byte.
        do_reset(1'b1, 1'b1);
        send(8'h04); send(8'h5A); send(8'h6B); send(8'h7C); send(8'h8D);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) seen = 1;
        end
        check("t5_first_seen", 32'(seen), 32'd1);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("t5_stalled_valid", 32'(out_valid), 32'd0);
        check("t5_stalled_rd", 32'(fifo_rd_en), 32'd0);
        check("t5_stalled_busy", 32'(busy), 32'd1);
        check("t5_stalled_pkts", 32'(pkt_count), 32'd0);
        drain(50);

        // Test 6: reset mid-packet with a read in flight, then refill.
        do_reset(1'b1, 1'b1);
        send(8'h05);
        for (int i = 0; i < 5; i++) send(8'h90 + 8'(i));
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("t6_first_seen", 32'(seen), 32'd1);
        do_reset(1'b1, 1'b1);
        send(8'h01); send(8'hEE);
        drain(50);
        check("t6_pkts", 32'(pkt_count), 32'd1);

        // Randomized run: a 255-byte packet, then many short ones.
        do_reset(1'b1, 1'b1);
        rnd_bytes.push_back(8'd255);
        for (int i = 0; i < 255; i++) rnd_bytes.push_back(8'($urandom));
        for (int p = 0; p < 120; p++) begin
            plen = $urandom_range(0, 6);
            rnd_bytes.push_back(8'(plen));
            for (int i = 0; i < plen; i++) rnd_bytes.push_back(8'($urandom));
        end
        idx = 0;
        for (int c = 0; c < 20000 && idx < rnd_bytes.size(); c++) begin
            @(negedge clk);
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 2 && idx < rnd_bytes.size(); j++) begin
                    send(rnd_bytes[idx]);
                    idx++;
                end
            end
        end
        check("rnd_all_sent", 32'(idx), 32'(rnd_bytes.size()));
        drain(5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
- Read-side consumer for the synchronous byte FIFO.
- Drives the FIFO's rd_en and absorbs its 1-cycle registered read latency.
- Deframes a length-prefixed byte stream: header byte L, then L payload bytes. Emits the payload on a valid/ready stream with an end-of-packet marker.
- Sits between the FIFO read port and downstream packet consumers. Shares clk and rst with the FIFO.

Parameters:
- BUF_DEPTH, 3, internal holding-buffer entries. The value 3 is required for full rate with no ready-to-rd_en combinational path. Values below 3 are not supported.
- CNT_W, 16, width of the packet and zero-length statistics counters.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  permits new FIFO reads. Buffered and in-flight data still drains when low.
- fifo_empty  input  1  FIFO empty flag (registered-count based)
- fifo_data  input  8  FIFO read data, valid the cycle after an accepted read
- fifo_rd_en  output  1  FIFO read request
- out_data  output  8  payload byte
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts; transfer = out_valid & out_ready
- out_last  output  1  marks the final payload byte of a packet, qualified by out_valid
- pkt_len  output  8  length field of the current/most recent packet
- busy  output  1  high while in S_PAY or any byte is buffered/in flight
- pkt_count  output  CNT_W  completed non-empty packets, wraps
- zero_len_count  output  CNT_W  headers with L=0, wraps

Behaviour:
- Reset (synchronous, rst=1 at edge): all outputs and state reset.
  - fifo_rd_en=0, out_valid=0, out_data=0, out_last=0, pkt_len=0, busy=0, pkt_count=0, zero_len_count=0.
  - Buffer occupancy=0, in-flight=0, state=S_HDR.
  - Any in-flight FIFO byte is discarded. rst mid-packet abandons the packet without incrementing pkt_count.
- Read issue: fifo_rd_en = enable & !fifo_empty & (occ + inflight < BUF_DEPTH), where occ and inflight are registers.
  - inflight is set the cycle after fifo_rd_en=1. At that next edge, fifo_data is written to the buffer tail.
  - No dependence on out_ready, so there is no combinational path from out_ready to fifo_rd_en.
- Buffer: FIFO-ordered. Push and pop in the same cycle are allowed. Occupancy never exceeds BUF_DEPTH.
- State machine:
  - S_HDR: when occ>0, consume the head byte as L (1 cycle, out_valid=0) and latch pkt_len=L.
    - L=0: increment zero_len_count, stay in S_HDR.
    - L>0: rem=L, go to S_PAY.
  - S_PAY: out_valid = (occ>0), out_data = head byte, out_last = out_valid & (rem==1).
    - On transfer: pop the buffer, rem--.
    - On transfer with rem==1: pkt_count++, go to S_HDR.
  - The header byte is never presented on out_*.
- Throughput: 1 payload byte/cycle sustained with out_ready=1 and FIFO non-empty. Exactly 1 bubble per packet (header cycle).
- Backpressure: out_valid held and out_data/out_last stable until the transfer completes. The buffer fills to 3, then fifo_rd_en drops.
- enable deasserted mid-packet: no new reads. The remaining buffered bytes are delivered, then out_valid=0 until enable returns. The packet resumes with no loss.
- fifo_empty=1: no read issued. Reads are never issued speculatively, so inflight is never set for an ignored read.
- L=255 is legal. rem is 8 bits. Counters wrap at 2^CNT_W-1 -> 0.
- busy = (state==S_PAY) | (occ!=0) | inflight.

Test Plan:
1. FIFO preloaded [03,A1,B2,C3], enable=1 from cycle 0, out_ready=1.
   - fifo_rd_en high cycles 0-3.
   - out_valid cycles 3-5 with out_data A1,B2,C3; out_last only at cycle 5.
   - pkt_len=03, pkt_count=1 at cycle 6.
2. Back-to-back packets [02,11,22,01,33]: out_data 11,22 (last on 22), one bubble, then 33 (last). pkt_count=2.
3. Zero-length [00,01,44]: zero_len_count=1, 00 is never output, then 44 with out_last=1. pkt_count=1.
4. Preload [05,01..05], out_ready=0 for 10 cycles, then 1.
   - occ saturates at 3 and fifo_rd_en stays 0 while full.
   - Bytes 01..05 are then delivered in order with no loss or duplication.
5. enable dropped after the first payload byte of [04,..]: the remaining buffered bytes drain. On re-enable the rest arrive, out_last on the 4th byte.
6. rst asserted mid-packet with a read in flight.
   - All outputs are 0 the next cycle and pkt_count is unchanged.
   - After refill [01,EE]: single byte EE with out_last=1.
